// File: rtl/ex_pkg.sv
// Shared encodings for the EX stage: ALU/muldiv op codes, branch types, forwarding selects
// and the multi-cycle sequencer states.
package ex_pkg;

  typedef enum logic [3:0] {
    OpAdd   = 4'd0,
    OpSub   = 4'd1,
    OpAnd   = 4'd2,
    OpOr    = 4'd3,
    OpXor   = 4'd4,
    OpSll   = 4'd5,
    OpSrl   = 4'd6,
    OpSra   = 4'd7,
    OpSlt   = 4'd8,
    OpSltu  = 4'd9,
    OpMul   = 4'd10,
    OpMulhu = 4'd11,
    OpDivu  = 4'd12,
    OpRemu  = 4'd13
  } op_e;

  typedef enum logic [1:0] {
    BrNone = 2'd0,
    BrEq   = 2'd1,
    BrNe   = 2'd2,
    BrLtu  = 2'd3
  } br_e;

  typedef enum logic [1:0] {
    FwdReg  = 2'd0,
    FwdMem  = 2'd1,
    FwdWb   = 2'd2,
    FwdReg2 = 2'd3
  } fwd_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } md_state_e;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op >= 4'd10) && (op <= 4'd13);
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per cycle for XLEN
// cycles, with a start/done handshake that holds the result in DONE until the slot is free.
module muldiv_seq
  import ex_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  op_e             op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            slot_free_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned CntW = $clog2(XLEN);

  md_state_e       state_q;
  logic [CntW-1:0] cnt_q;
  logic [XLEN-1:0] hi_q, lo_q, b_q;
  logic [XLEN-1:0] hi_d, lo_d;
  logic            is_div_q, sel_hi_q;
  logic [XLEN:0]   mul_sum, div_trial;

  // {hi,lo} is the product register for multiply and {remainder,quotient} for divide.
  // A zero divisor never fails the trial subtract, giving all-ones quotient and
  // remainder equal to the dividend without special casing.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_trial = {hi_q, lo_q[XLEN-1]} - {1'b0, b_q};
    if (is_div_q) begin
      if (!div_trial[XLEN]) begin
        hi_d = div_trial[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_d = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
        lo_d = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_d = mul_sum[XLEN:1];
      lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
      sel_hi_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q  <= StRun;
            cnt_q    <= CntW'(XLEN - 1);
            hi_q     <= '0;
            lo_q     <= a_i;
            b_q      <= b_i;
            is_div_q <= op_i inside {OpDivu, OpRemu};
            sel_hi_q <= op_i inside {OpMulhu, OpRemu};
          end
        end
        StRun: begin
          hi_q <= hi_d;
          lo_q <= lo_d;
          if (cnt_q == '0) begin
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StDone: begin
          if (slot_free_i) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o   = (state_q != StIdle);
  assign done_o   = (state_q == StDone) && slot_free_i;
  assign result_o = sel_hi_q ? hi_q : lo_q;

endmodule

// File: rtl/ex_muldiv.sv
// EX pipeline stage: operand forwarding, single-cycle ALU and branch compare, plus an
// iterative mul/div unit, all feeding one valid/ready output register toward MEM.
module ex_muldiv
  import ex_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CTRL_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op_sel,
  input  logic              src_b_imm,
  input  logic [1:0]        br_type,
  input  logic [XLEN-1:0]   reg_a,
  input  logic [XLEN-1:0]   reg_b,
  input  logic [XLEN-1:0]   imm,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   wb_data,
  input  logic [1:0]        fwd_a_sel,
  input  logic [1:0]        fwd_b_sel,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   alu_out,
  output logic [XLEN-1:0]   reg_b_out,
  output logic [XLEN-1:0]   add_pc_out,
  output logic              branch_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              busy
);

  localparam int unsigned ShW = $clog2(XLEN);

  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   alu_q, alu_d, regb_q, regb_d, addpc_q, addpc_d;
  logic              br_q, br_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  // Side information parked while the iterative unit works.
  logic [XLEN-1:0]   md_regb_q, md_regb_d, md_pc_q, md_pc_d;
  logic              md_br_q, md_br_d;
  logic [CTRL_W-1:0] md_ctrl_q, md_ctrl_d;

  logic [XLEN-1:0] fwd_a, fwd_b, op_b, alu_res, add_pc, md_result;
  logic [ShW-1:0]  shamt;
  logic            br_taken, slot_free, accept, is_md, md_busy, md_done;

  always_comb begin
    case (fwd_e'(fwd_a_sel))
      FwdMem:  fwd_a = alu_q;
      FwdWb:   fwd_a = wb_data;
      default: fwd_a = reg_a;
    endcase
    case (fwd_e'(fwd_b_sel))
      FwdMem:  fwd_b = alu_q;
      FwdWb:   fwd_b = wb_data;
      default: fwd_b = reg_b;
    endcase
    op_b   = src_b_imm ? imm : fwd_b;
    shamt  = op_b[ShW-1:0];
    add_pc = pc + imm;

    case (op_e'(op_sel))
      OpAdd:   alu_res = fwd_a + op_b;
      OpSub:   alu_res = fwd_a - op_b;
      OpAnd:   alu_res = fwd_a & op_b;
      OpOr:    alu_res = fwd_a | op_b;
      OpXor:   alu_res = fwd_a ^ op_b;
      OpSll:   alu_res = fwd_a << shamt;
      OpSrl:   alu_res = fwd_a >> shamt;
      OpSra:   alu_res = $signed(fwd_a) >>> shamt;
      OpSlt:   alu_res = {{(XLEN-1){1'b0}}, $signed(fwd_a) < $signed(op_b)};
      OpSltu:  alu_res = {{(XLEN-1){1'b0}}, fwd_a < op_b};
      default: alu_res = '0;
    endcase

    case (br_e'(br_type))
      BrEq:    br_taken = (fwd_a == op_b);
      BrNe:    br_taken = (fwd_a != op_b);
      BrLtu:   br_taken = (fwd_a < op_b);
      default: br_taken = 1'b0;
    endcase
  end

  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = !md_busy && slot_free;
  assign accept    = in_valid && in_ready;
  assign is_md     = is_muldiv(op_sel);

  muldiv_seq #(
    .XLEN (XLEN)
  ) u_muldiv_seq (
    .clk_i       (clk),
    .rst_ni      (reset),
    .start_i     (accept && is_md),
    .op_i        (op_e'(op_sel)),
    .a_i         (fwd_a),
    .b_i         (op_b),
    .slot_free_i (slot_free),
    .busy_o      (md_busy),
    .done_o      (md_done),
    .result_o    (md_result)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    alu_d       = alu_q;
    regb_d      = regb_q;
    addpc_d     = addpc_q;
    br_d        = br_q;
    ctrl_d      = ctrl_q;
    md_regb_d   = md_regb_q;
    md_pc_d     = md_pc_q;
    md_br_d     = md_br_q;
    md_ctrl_d   = md_ctrl_q;

    if (accept && is_md) begin
      md_regb_d = fwd_b;
      md_pc_d   = add_pc;
      md_br_d   = br_taken;
      md_ctrl_d = ctrl_in;
    end

    // md_done only occurs while busy, so it can never coincide with an accept.
    if (accept && !is_md) begin
      out_valid_d = 1'b1;
      alu_d       = alu_res;
      regb_d      = fwd_b;
      addpc_d     = add_pc;
      br_d        = br_taken;
      ctrl_d      = ctrl_in;
    end else if (md_done) begin
      out_valid_d = 1'b1;
      alu_d       = md_result;
      regb_d      = md_regb_q;
      addpc_d     = md_pc_q;
      br_d        = md_br_q;
      ctrl_d      = md_ctrl_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      alu_q       <= '0;
      regb_q      <= '0;
      addpc_q     <= '0;
      br_q        <= 1'b0;
      ctrl_q      <= '0;
      md_regb_q   <= '0;
      md_pc_q     <= '0;
      md_br_q     <= 1'b0;
      md_ctrl_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      alu_q       <= alu_d;
      regb_q      <= regb_d;
      addpc_q     <= addpc_d;
      br_q        <= br_d;
      ctrl_q      <= ctrl_d;
      md_regb_q   <= md_regb_d;
      md_pc_q     <= md_pc_d;
      md_br_q     <= md_br_d;
      md_ctrl_q   <= md_ctrl_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign alu_out    = alu_q;
  assign reg_b_out  = regb_q;
  assign add_pc_out = addpc_q;
  assign branch_out = br_q;
  assign ctrl_out   = ctrl_q;
  assign busy       = md_busy;

endmodule
